// File: rtl/active_demapper_if.sv
// Symbol-in / demapped-out signal bundle for active_demapper.
// master drives received symbols and observes results; slave is the demapper.
interface active_demapper_if #(
    parameter int CW = 7
);
    logic          sym_valid;
    logic [7:0]    sym_in;
    logic          sym_ctrl;
    logic [7:0]    dm_data;
    logic          dm_data_valid;
    logic          dm_stuffing;
    logic          dm_tu_done;
    logic [CW-1:0] dm_tu_data_cnt;
    logic [CW-1:0] dm_stuff_cnt;
    logic          dm_err;
    logic [1:0]    dm_err_code;

    modport master (
        output sym_valid, sym_in, sym_ctrl,
        input  dm_data, dm_data_valid, dm_stuffing, dm_tu_done,
               dm_tu_data_cnt, dm_stuff_cnt, dm_err, dm_err_code
    );

    modport slave (
        input  sym_valid, sym_in, sym_ctrl,
        output dm_data, dm_data_valid, dm_stuffing, dm_tu_done,
               dm_tu_data_cnt, dm_stuff_cnt, dm_err, dm_err_code
    );
endinterface

// File: rtl/active_demapper.sv
// RX active-region demapper: strips FS..FE stuffing, tracks TU boundaries, flags framing errors.
// Optional ACTIVE_DEMAPPER_STUFF_CHECK_EN: non-zero stuffed symbols raise error 11.
// No backpressure: every slot with sym_valid high is consumed; sym_valid low is a no-op slot.
module active_demapper #(
    parameter int TU_SIZE = 64,
    parameter int CW      = $clog2(TU_SIZE + 1)
) (
    input  logic              clk,
    input  logic              rst,
    active_demapper_if.slave  bus,
    output logic              dbg_state_o
);
    typedef enum logic {ST_DATA = 1'b0, ST_STUFF = 1'b1} state_t;

    localparam logic [7:0] SYM_FS = 8'hFC;
    localparam logic [7:0] SYM_FE = 8'hFE;

    state_t        state_q, state_d;
    logic [CW-1:0] pos_q, pos_d;
    logic [CW-1:0] data_cnt_q, data_cnt_d;
    logic [CW-1:0] stuff_cnt_q, stuff_cnt_d;
    logic [7:0]    data_q, data_d;
    logic          data_valid_q, data_valid_d;
    logic          stuffing_q, stuffing_d;
    logic          tu_done_q, tu_done_d;
    logic [CW-1:0] tu_data_cnt_q, tu_data_cnt_d;
    logic [CW-1:0] tu_stuff_cnt_q, tu_stuff_cnt_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;

    logic          is_fs, is_fe, at_last, tu_close;
    logic          err01, err10, err11, data_inc, stuff_inc;
    logic [CW-1:0] data_sum, stuff_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_DATA;
            pos_q          <= '0;
            data_cnt_q     <= '0;
            stuff_cnt_q    <= '0;
            data_q         <= 8'h00;
            data_valid_q   <= 1'b0;
            stuffing_q     <= 1'b0;
            tu_done_q      <= 1'b0;
            tu_data_cnt_q  <= '0;
            tu_stuff_cnt_q <= '0;
            err_q          <= 1'b0;
            err_code_q     <= 2'b00;
        end else begin
            state_q        <= state_d;
            pos_q          <= pos_d;
            data_cnt_q     <= data_cnt_d;
            stuff_cnt_q    <= stuff_cnt_d;
            data_q         <= data_d;
            data_valid_q   <= data_valid_d;
            stuffing_q     <= stuffing_d;
            tu_done_q      <= tu_done_d;
            tu_data_cnt_q  <= tu_data_cnt_d;
            tu_stuff_cnt_q <= tu_stuff_cnt_d;
            err_q          <= err_d;
            err_code_q     <= err_code_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pos_d          = pos_q;
        data_cnt_d     = data_cnt_q;
        stuff_cnt_d    = stuff_cnt_q;
        data_d         = data_q;
        data_valid_d   = 1'b0;
        stuffing_d     = 1'b0;
        tu_done_d      = 1'b0;
        tu_data_cnt_d  = tu_data_cnt_q;
        tu_stuff_cnt_d = tu_stuff_cnt_q;
        err_d          = 1'b0;
        err_code_d     = err_code_q;
        is_fs          = bus.sym_ctrl && (bus.sym_in == SYM_FS);
        is_fe          = bus.sym_ctrl && (bus.sym_in == SYM_FE);
        at_last        = (pos_q == CW'(TU_SIZE - 1));
        tu_close       = 1'b0;
        err01          = 1'b0;
        err10          = 1'b0;
        err11          = 1'b0;
        data_inc       = 1'b0;
        stuff_inc      = 1'b0;
        data_sum       = '0;
        stuff_sum      = '0;

        if (bus.sym_valid) begin
            case (state_q)
                ST_DATA: begin
                    if (!bus.sym_ctrl) begin
                        data_d       = bus.sym_in;
                        data_valid_d = 1'b1;
                        data_inc     = 1'b1;
                    end else if (is_fs) begin
                        state_d    = ST_STUFF;
                        stuffing_d = 1'b1;
                    end else if (is_fe) begin
                        err10 = 1'b1;
                    end else begin
                        err11 = 1'b1;
                    end
                end
                default: begin
                    stuffing_d = 1'b1;
                    if (!bus.sym_ctrl) begin
                        stuff_inc = 1'b1;
`ifdef ACTIVE_DEMAPPER_STUFF_CHECK_EN
                        err11 = (bus.sym_in != 8'h00);
`endif
                    end else if (is_fe) begin
                        state_d = ST_DATA;
                        err10   = !at_last;
                    end else if (is_fs) begin
                        err01 = 1'b1;
                    end else begin
                        err11 = 1'b1;
                    end
                    // Stuffing may not straddle a TU boundary.
                    if (at_last && !is_fe) err10 = 1'b1;
                end
            endcase

            // Any FE (accepted or misplaced) realigns the TU.
            tu_close  = at_last || is_fe;
            data_sum  = data_cnt_q + CW'(data_inc);
            stuff_sum = stuff_cnt_q + CW'(stuff_inc);
            if (tu_close) begin
                tu_done_d      = 1'b1;
                tu_data_cnt_d  = data_sum;
                tu_stuff_cnt_d = stuff_sum;
                pos_d          = '0;
                data_cnt_d     = '0;
                stuff_cnt_d    = '0;
            end else begin
                pos_d       = pos_q + CW'(1);
                data_cnt_d  = data_sum;
                stuff_cnt_d = stuff_sum;
            end

            err_d = err01 || err10 || err11;
            if (err01)      err_code_d = 2'b01;
            else if (err10) err_code_d = 2'b10;
            else if (err11) err_code_d = 2'b11;
        end
    end

    assign bus.dm_data        = data_q;
    assign bus.dm_data_valid  = data_valid_q;
    assign bus.dm_stuffing    = stuffing_q;
    assign bus.dm_tu_done     = tu_done_q;
    assign bus.dm_tu_data_cnt = tu_data_cnt_q;
    assign bus.dm_stuff_cnt   = tu_stuff_cnt_q;
    assign bus.dm_err         = err_q;
    assign bus.dm_err_code    = err_code_q;
    assign dbg_state_o        = state_q;
endmodule

// File: tb/tb_active_demapper.sv
// Bench for active_demapper: directed symbol streams, expected bytes/TU counts/error codes
// queued at issue time and matched by an independent monitor on the falling edge.
module tb_active_demapper;
    localparam int TU = 64;
    localparam int CW = $clog2(TU + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dbg_state;

    int checks = 0;
    int errors = 0;

    logic [7:0]      exp_data_q[$];
    logic [2*CW-1:0] exp_tu_q[$];
    logic [1:0]      exp_err_q[$];

    active_demapper_if #(.CW(CW)) bus ();

    active_demapper #(.TU_SIZE(TU)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic slot(input logic [7:0] sym, input logic ctrl);
        @(negedge clk);
        bus.sym_valid = 1'b1;
        bus.sym_in    = sym;
        bus.sym_ctrl  = ctrl;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.sym_valid = 1'b0;
            bus.sym_in    = 8'hA5;
            bus.sym_ctrl  = 1'b0;
        end
    endtask

    task automatic data_byte(input logic [7:0] b);
        slot(b, 1'b0);
        exp_data_q.push_back(b);
    endtask

    task automatic push_tu(input int d, input int s);
        exp_tu_q.push_back({CW'(d), CW'(s)});
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.dm_data_valid) begin
                checks++;
                if (exp_data_q.size() == 0) begin
                    errors++;
                    $display("FAIL data_unexpected got=%0h", bus.dm_data);
                end else begin
                    logic [7:0] e;
                    e = exp_data_q.pop_front();
                    checks--;
                    check("data", {24'd0, bus.dm_data}, {24'd0, e});
                end
            end
            if (bus.dm_tu_done) begin
                checks++;
                if (exp_tu_q.size() == 0) begin
                    errors++;
                    $display("FAIL tu_unexpected got data_cnt=%0d stuff_cnt=%0d",
                             bus.dm_tu_data_cnt, bus.dm_stuff_cnt);
                end else begin
                    logic [2*CW-1:0] e;
                    e = exp_tu_q.pop_front();
                    checks--;
                    check("tu_data_cnt", 32'(bus.dm_tu_data_cnt), 32'(e[2*CW-1:CW]));
                    check("tu_stuff_cnt", 32'(bus.dm_stuff_cnt), 32'(e[CW-1:0]));
                end
            end
            if (bus.dm_err) begin
                checks++;
                if (exp_err_q.size() == 0) begin
                    errors++;
                    $display("FAIL err_unexpected got code=%0b", bus.dm_err_code);
                end else begin
                    logic [1:0] e;
                    e = exp_err_q.pop_front();
                    checks--;
                    check("err_code", 32'(bus.dm_err_code), 32'(e));
                end
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_data"},       32'(bus.dm_data), 32'h00);
        check({tag, "_data_valid"}, 32'(bus.dm_data_valid), 32'h0);
        check({tag, "_stuffing"},   32'(bus.dm_stuffing), 32'h0);
        check({tag, "_tu_done"},    32'(bus.dm_tu_done), 32'h0);
        check({tag, "_tu_data"},    32'(bus.dm_tu_data_cnt), 32'h0);
        check({tag, "_tu_stuff"},   32'(bus.dm_stuff_cnt), 32'h0);
        check({tag, "_err"},        32'(bus.dm_err), 32'h0);
        check({tag, "_err_code"},   32'(bus.dm_err_code), 32'h0);
        check({tag, "_state"},      32'(dbg_state), 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.sym_valid = 1'b0;
        bus.sym_in    = 8'h00;
        bus.sym_ctrl  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // T1: 40 data, FS, 22 stuff, FE at pos 63
        for (int i = 1; i <= 40; i++) data_byte(8'(i));
        slot(8'hFC, 1'b1);
        for (int i = 0; i < 22; i++) slot(8'h00, 1'b0);
        slot(8'hFE, 1'b1);
        push_tu(40, 22);

        // T2: 64 data bytes, no control
        for (int i = 0; i < 64; i++) data_byte(8'(i * 3 + 7));
        push_tu(64, 0);

        // T3: FS, FS (err 01), stuff until FE at pos 63
        for (int i = 0; i < 20; i++) data_byte(8'(8'h80 + i));
        slot(8'hFC, 1'b1);
        slot(8'hFC, 1'b1);
        exp_err_q.push_back(2'b01);
        for (int i = 0; i < 41; i++) slot(8'h00, 1'b0);
        slot(8'hFE, 1'b1);
        push_tu(20, 41);

        // T4: FE in DATA at pos 10, then a full TU from pos 0
        for (int i = 0; i < 10; i++) data_byte(8'(8'h40 + i));
        slot(8'hFE, 1'b1);
        exp_err_q.push_back(2'b10);
        push_tu(10, 0);
        for (int i = 0; i < 64; i++) data_byte(8'(255 - i));
        push_tu(64, 0);

        // T5: non-zero stuffed symbol
        slot(8'hFC, 1'b1);
        slot(8'h5A, 1'b0);
`ifdef ACTIVE_DEMAPPER_STUFF_CHECK_EN
        exp_err_q.push_back(2'b11);
`endif
        for (int i = 0; i < 61; i++) slot(8'h00, 1'b0);
        slot(8'hFE, 1'b1);
        push_tu(0, 62);

        // T6: stuffing runs into the TU boundary, stray FE next TU
        slot(8'hFC, 1'b1);
        for (int i = 0; i < 63; i++) slot(8'h00, 1'b0);
        exp_err_q.push_back(2'b10);
        push_tu(0, 63);
        idle(1);
        @(negedge clk);
        check("boundary_state_stuff", 32'(dbg_state), 32'h1);
        slot(8'hFE, 1'b1);
        exp_err_q.push_back(2'b10);
        push_tu(0, 0);

        // T7: illegal control in DATA (dropped), FS then early FE
        for (int i = 0; i < 5; i++) data_byte(8'(8'h11 * (i + 1)));
        slot(8'h3C, 1'b1);
        exp_err_q.push_back(2'b11);
        slot(8'hFC, 1'b1);
        slot(8'hFE, 1'b1);
        exp_err_q.push_back(2'b10);
        push_tu(5, 0);

        // T8: FS + stuffing with gaps, async reset mid-STUFF, then full TU
        slot(8'hFC, 1'b1);
        for (int i = 0; i < 5; i++) begin
            slot(8'h00, 1'b0);
            idle(1);
        end
        @(negedge clk);
        check("pre_reset_state_stuff", 32'(dbg_state), 32'h1);
        #2 rst = 1'b1;
        #1 check_reset_values("async_reset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) data_byte(8'(i ^ 8'h5C));
        push_tu(64, 0);

        idle(4);
        check("data_q_drained", 32'(exp_data_q.size()), 32'd0);
        check("tu_q_drained",   32'(exp_tu_q.size()), 32'd0);
        check("err_q_drained",  32'(exp_err_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/active_demapper.md
# active_demapper

Receive-side counterpart of the stream active mapper. It consumes the per-lane active-region symbol stream (data symbols, zero-valued stuffing symbols, and the FS 0xFC / FE 0xFE control symbols with their control flag) and recovers the main stream data bytes. It also tracks transfer-unit (TU) boundaries, measures the stuffing length per TU and flags framing errors. It sits after symbol decode/descramble in the RX lane path and feeds the pixel unpacker.

## Interface
- TU_SIZE, 64, symbols per transfer unit; legal range 32..64.
- CW, $clog2(TU_SIZE+1), width of the per-TU counts.
- clk  in  1  symbol clock.
- rst  in  1  asynchronous, active-high reset.
- sym_valid  in  1  symbol slot qualifier; when low the slot is ignored entirely.
- sym_in  in  8  received symbol.
- sym_ctrl  in  1  sym_in is a control symbol.
- dm_data  out  8  recovered main stream byte.
- dm_data_valid  out  1  dm_data holds a valid main byte this cycle.
- dm_stuffing  out  1  the slot just consumed was inside FS..FE (FS and FE inclusive).
- dm_tu_done  out  1  one-cycle pulse on the last slot of a TU.
- dm_tu_data_cnt  out  CW  data symbols in the completed TU; valid with dm_tu_done.
- dm_stuff_cnt  out  CW  stuffed (non-control) symbols between FS and FE in the completed TU; valid with dm_tu_done.
- dm_err  out  1  one-cycle framing error pulse.
- dm_err_code  out  2  cause of the error: 01 FS while stuffing, 10 FE misplaced, 11 illegal control or stuff symbol; valid with dm_err.

## Operation
- States:
  - DATA: reset state.
  - STUFF: entered on FS, left on FE.
- Per valid slot, in DATA:
  - sym_ctrl=0: data byte. Output it and increment the data count.
  - sym_ctrl=1, 0xFC: go to STUFF.
  - sym_ctrl=1, 0xFE: error 10. Stay in DATA.
  - Any other control value: error 11. Slot dropped.
- Per valid slot, in STUFF:
  - sym_ctrl=0: stuffed symbol. Increment the stuff count. No data output.
  - 0xFE: go to DATA.
  - 0xFC: error 01. Stay in STUFF.
  - Other control value: error 11.
- TU position counter pos (0..TU_SIZE-1):
  - Increments on every valid slot, including control and erroneous slots.
  - The TU closes when pos = TU_SIZE-1, or on any accepted FE.
  - On close: pulse dm_tu_done, present both counts, then clear pos and both counts.
- FE placement:
  - An FE accepted at pos ≠ TU_SIZE-1 closes the TU early, raises error 10, and resynchronises pos to 0 on the next slot.
  - pos reaching TU_SIZE-1 while in STUFF with no FE: error 10, TU closes, state stays STUFF. Stuffing legitimately spanning a boundary is not supported.
- A TU containing no FS/FE (all data) is legal and closes at TU_SIZE-1 with dm_stuff_cnt=0.
- FS immediately followed by FE is legal: dm_stuff_cnt=0.
- Error priority when several apply to one slot: 01 > 10 > 11. Only one code is reported per slot.
- Count arithmetic is unsigned CW-bit and cannot overflow, because counts clear at every TU close.

## Timing
- All outputs are registered. Latency is 1 cycle from the sym_valid slot to dm_data_valid, dm_stuffing, dm_tu_done and dm_err.
- sym_valid low:
  - dm_data_valid, dm_tu_done and dm_err are 0 next cycle.
  - dm_data, counts, state and pos hold.
- Reset values: dm_data=0x00, dm_data_valid=0, dm_stuffing=0, dm_tu_done=0, dm_tu_data_cnt=0, dm_stuff_cnt=0, dm_err=0, dm_err_code=00, state=DATA, pos=0.
- Reset asserted mid-TU or mid-STUFF: all outputs return to reset values asynchronously. The first valid slot after release is pos 0 in DATA.
- dm_tu_done and dm_err may assert in the same cycle.
- No backpressure: every valid slot is consumed.

## Configuration
- ACTIVE_DEMAPPER_STUFF_CHECK_EN:
  - Defined: a stuffed symbol in STUFF whose value is not 0x00 raises error 11. It is still counted in dm_stuff_cnt.
  - Undefined: stuffed symbol values are ignored, and error 11 arises only from illegal control values.

## Test plan
- Reset, then one TU of 40 data bytes 0x01..0x28, FC, 22 × 0x00, FE (TU_SIZE=64) -> 40 bytes output with 1-cycle latency; dm_tu_done at FE slot with data_cnt=40, stuff_cnt=22; no error.
- 64 data bytes with no control symbols -> dm_tu_done on the 64th byte, data_cnt=64, stuff_cnt=0.
- FC, FC mid-TU -> dm_err, code 01 on the second FC; state remains STUFF; the following FE at pos 63 closes the TU cleanly.
- FE in DATA at pos 10 -> dm_err code 10, dm_tu_done at that slot with data_cnt=10; next slot counts as pos 0.
- FC then 0x5A stuffed byte -> error 11 with ACTIVE_DEMAPPER_STUFF_CHECK_EN defined, no error without it; stuff_cnt includes the byte in both cases.
- Stream of FC plus 5 stuffed symbols with sym_valid gaps, then rst pulsed -> all outputs return to reset values; the next 64 data bytes close a TU with data_cnt=64.
